// File: rtl/mand_pkg.sv
// Shared fixed-point constants and scheduler state encoding for the Mandelbrot pipeline.
package mand_pkg;

  localparam int unsigned MAND_WORD = 27;
  localparam int unsigned MAND_FRAC = 20;
  localparam logic [MAND_WORD-1:0] FIX_ONE = MAND_WORD'(1) << MAND_FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    EMIT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/mand_coord_step.sv
// Raster x/y counters and c_re/c_im accumulators; c is built by repeated addition only.
module mand_coord_step
  import mand_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned X_BITS = 10,
  parameter int unsigned Y_BITS = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 advance,
  input  logic [MAND_WORD-1:0] re_origin,
  input  logic [MAND_WORD-1:0] im_origin,
  input  logic [MAND_WORD-1:0] step,
  output logic [X_BITS-1:0]    x,
  output logic [Y_BITS-1:0]    y,
  output logic [MAND_WORD-1:0] c_re,
  output logic [MAND_WORD-1:0] c_im,
  output logic                 last
);

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(HEIGHT - 1);

  logic [MAND_WORD-1:0] re_org_q;
  logic [MAND_WORD-1:0] step_q;
  logic                 x_last;
  logic                 y_last;

  assign x_last = (x == X_MAX);
  assign y_last = (y == Y_MAX);
  assign last   = x_last && y_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      re_org_q <= '0;
      step_q   <= '0;
      x        <= '0;
      y        <= '0;
      c_re     <= '0;
      c_im     <= '0;
    end else if (init) begin
      re_org_q <= re_origin;
      step_q   <= step;
      x        <= '0;
      y        <= '0;
      c_re     <= re_origin;
      c_im     <= im_origin;
    end else if (advance) begin
      if (!x_last) begin
        x    <= x + 1'b1;
        c_re <= c_re + step_q;
      end else if (!y_last) begin
        x    <= '0;
        y    <= y + 1'b1;
        c_re <= re_org_q;
        // Imaginary axis decreases going down the frame.
        c_im <= c_im - step_q;
      end
    end
  end

endmodule

// File: rtl/mand_pixel_scheduler.sv
// Per-pixel sequencer for one mand_solver: restarts it, holds c, and hands results downstream.
module mand_pixel_scheduler
  import mand_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned X_BITS = 10,
  parameter int unsigned Y_BITS = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MAND_WORD-1:0] re_origin,
  input  logic [MAND_WORD-1:0] im_origin,
  input  logic [MAND_WORD-1:0] step,
  output logic                 solver_reset,
  output logic [MAND_WORD-1:0] c_re,
  output logic [MAND_WORD-1:0] c_im,
  input  logic                 solver_ready,
  input  logic [31:0]          solver_out,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [X_BITS-1:0]    pix_x,
  output logic [Y_BITS-1:0]    pix_y,
  output logic [31:0]          pix_iter,
  output logic                 busy,
  output logic                 frame_done
);

  sched_state_t          state;
  logic                  first_wait;
  logic                  init;
  logic                  advance;
  logic                  last;
  logic [X_BITS-1:0]     x;
  logic [Y_BITS-1:0]     y;

  assign init         = (state == IDLE) && start;
  assign advance      = (state == EMIT) && pix_ready;
  assign solver_reset = (state == IDLE) || (state == LOAD);
  assign busy         = (state != IDLE);

  mand_coord_step #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_coord (
    .clock     (clock),
    .reset     (reset),
    .init      (init),
    .advance   (advance),
    .re_origin (re_origin),
    .im_origin (im_origin),
    .step      (step),
    .x         (x),
    .y         (y),
    .c_re      (c_re),
    .c_im      (c_im),
    .last      (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      first_wait <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_iter   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) state <= LOAD;
        end
        LOAD: begin
          state      <= WAIT;
          first_wait <= 1'b1;
        end
        WAIT: begin
          first_wait <= 1'b0;
          // The solver's ready may still be left over from the previous pixel on the first cycle.
          if (!first_wait && solver_ready) begin
            pix_iter  <= solver_out;
            pix_x     <= x;
            pix_y     <= y;
            pix_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (last) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mand_pixel_scheduler.sv
// Randomized bench for mand_pixel_scheduler against a raster/c reference model and a solver stub.
module tb_mand_pixel_scheduler;
  import mand_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned XB = 2;
  localparam int unsigned YB = 1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [MAND_WORD-1:0] re_origin = '0;
  logic [MAND_WORD-1:0] im_origin = '0;
  logic [MAND_WORD-1:0] step = '0;
  logic                 solver_reset;
  logic [MAND_WORD-1:0] c_re;
  logic [MAND_WORD-1:0] c_im;
  logic                 solver_ready = 1'b0;
  logic [31:0]          solver_out = '0;
  logic                 pix_valid;
  logic                 pix_ready = 1'b0;
  logic [XB-1:0]        pix_x;
  logic [YB-1:0]        pix_y;
  logic [31:0]          pix_iter;
  logic                 busy;
  logic                 frame_done;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mand_pixel_scheduler #(
    .WIDTH  (W),
    .HEIGHT (H),
    .X_BITS (XB),
    .Y_BITS (YB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .re_origin    (re_origin),
    .im_origin    (im_origin),
    .step         (step),
    .solver_reset (solver_reset),
    .c_re         (c_re),
    .c_im         (c_im),
    .solver_ready (solver_ready),
    .solver_out   (solver_out),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_iter     (pix_iter),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // Stub solver: result is a fixed function of c, so a wrong c shows up as a wrong pix_iter.
  function automatic logic [31:0] solver_fn(input logic [MAND_WORD-1:0] r, input logic [MAND_WORD-1:0] i);
    return {5'b0, r} ^ {i, 5'b0} ^ 32'h5A5A_0000;
  endfunction

  // Ready stays stale through reset and clears one edge after it, like the real solver.
  logic [2:0] lat  = 3'd1;
  logic [3:0] scnt = '0;
  logic       sprev = 1'b1;
  always @(posedge clock) begin
    if (solver_reset) begin
      scnt  <= '0;
      sprev <= 1'b1;
      lat   <= 3'($urandom_range(1, 4));
    end else if (sprev) begin
      sprev        <= 1'b0;
      solver_ready <= 1'b0;
      scnt         <= 4'd1;
    end else begin
      scnt <= scnt + 1'b1;
      if (scnt == 4'(lat)) begin
        solver_ready <= 1'b1;
        solver_out   <= solver_fn(c_re, c_im);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_pixel(input int x, input int y, input logic [MAND_WORD-1:0] ro,
                          input logic [MAND_WORD-1:0] io, input logic [MAND_WORD-1:0] st,
                          input int stall, input bit noise);
    logic [MAND_WORD-1:0] er;
    logic [MAND_WORD-1:0] ei;
    logic [31:0] ex_iter;
    int n;
    er = ro + MAND_WORD'(x) * st;
    ei = io - MAND_WORD'(y) * st;
    ex_iter = solver_fn(er, ei);
    n = 0;
    while (pix_valid !== 1'b1 && n < 100) begin
      if (noise && n == 1) begin
        start     = 1'b1;
        re_origin = MAND_WORD'($urandom);
        im_origin = MAND_WORD'($urandom);
        step      = MAND_WORD'($urandom);
      end
      @(negedge clock);
      start = 1'b0;
      n++;
    end
    chk("pix_valid_rise", {31'b0, pix_valid}, 32'd1);
    chk("pix_x", 32'(pix_x), 32'(x));
    chk("pix_y", 32'(pix_y), 32'(y));
    chk("pix_iter", pix_iter, ex_iter);
    chk("busy_emit", {31'b0, busy}, 32'd1);
    for (int s = 0; s < stall; s++) begin
      pix_ready = 1'b0;
      @(negedge clock);
      chk("bp_valid", {31'b0, pix_valid}, 32'd1);
      chk("bp_xy", {16'(pix_x), 16'(pix_y)}, {16'(x), 16'(y)});
      chk("bp_iter", pix_iter, ex_iter);
      chk("bp_no_load", {31'b0, solver_reset}, 32'd0);
    end
    pix_ready = 1'b1;
    @(negedge clock);
    pix_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [MAND_WORD-1:0] ro, input logic [MAND_WORD-1:0] io,
                           input logic [MAND_WORD-1:0] st, input bit rnd_stall, input int stall,
                           input bit noise);
    re_origin = ro;
    im_origin = io;
    step      = st;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("load_busy", {31'b0, busy}, 32'd1);
    chk("load_solver_reset", {31'b0, solver_reset}, 32'd1);
    chk("load_c_re", 32'(c_re), 32'(ro));
    chk("load_c_im", 32'(c_im), 32'(io));
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        do_pixel(x, y, ro, io, st, rnd_stall ? int'($urandom_range(0, 3)) : stall, noise);
        if (!(x == int'(W) - 1 && y == int'(H) - 1)) begin
          chk("valid_drop", {31'b0, pix_valid}, 32'd0);
          chk("mid_frame_done", {31'b0, frame_done}, 32'd0);
        end
      end
    end
    chk("frame_done", {31'b0, frame_done}, 32'd1);
    chk("done_busy", {31'b0, busy}, 32'd0);
    chk("done_valid", {31'b0, pix_valid}, 32'd0);
    chk("idle_solver_reset", {31'b0, solver_reset}, 32'd1);
    @(negedge clock);
    chk("frame_done_pulse", {31'b0, frame_done}, 32'd0);
  endtask

  initial begin
    logic [MAND_WORD-1:0] ro;
    logic [MAND_WORD-1:0] io;
    logic [MAND_WORD-1:0] st;

    repeat (2) @(negedge clock);
    chk("rst_solver_reset", {31'b0, solver_reset}, 32'd1);
    chk("rst_c", {5'b0, c_re} | {5'b0, c_im}, 32'd0);
    chk("rst_pix", {31'b0, pix_valid} | 32'(pix_x) | 32'(pix_y) | pix_iter, 32'd0);
    chk("rst_busy_done", {30'b0, busy, frame_done}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed frame: -2.0 + 1.0j, step 0.5.
    ro = '0 - (FIX_ONE << 1);
    io = FIX_ONE;
    st = FIX_ONE >> 1;
    run_frame(ro, io, st, 1'b0, 0, 1'b0);

    // Long backpressure on every pixel.
    run_frame(ro, io, st, 1'b0, 10, 1'b0);

    // start pulses and origin changes mid-frame must be ignored.
    run_frame(MAND_WORD'($urandom), MAND_WORD'($urandom), MAND_WORD'($urandom), 1'b1, 0, 1'b1);

    // Wrap from most-positive to most-negative c_re.
    run_frame(27'h3FF_FFFF, MAND_WORD'($urandom), 27'd1, 1'b0, 0, 1'b0);

    // Asynchronous reset between edges while waiting on pixel (3,0).
    ro = MAND_WORD'($urandom);
    io = MAND_WORD'($urandom);
    st = MAND_WORD'($urandom);
    re_origin = ro;
    im_origin = io;
    step      = st;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int x = 0; x < 3; x++) do_pixel(x, 0, ro, io, st, 0, 1'b0);
    @(negedge clock);
    chk("pre_rst_wait", {30'b0, busy, solver_reset}, 32'd2);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_solver_reset", {31'b0, solver_reset}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_c", {5'b0, c_re} | {5'b0, c_im}, 32'd0);
    chk("arst_pix", {31'b0, pix_valid} | 32'(pix_x) | 32'(pix_y) | pix_iter, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("arst_no_done", {30'b0, frame_done, busy}, 32'd0);
    end
    run_frame(ro, io, st, 1'b1, 0, 1'b0);

    // Random frames.
    for (int f = 0; f < 4; f++)
      run_frame(MAND_WORD'($urandom), MAND_WORD'($urandom), MAND_WORD'($urandom), 1'b1, 0,
                1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
